// File: rtl/dmg_oam_dma.sv
// OAM DMA engine: copies 160 bytes from page {src_hi,00} into OAM, one byte per M-cycle.
// Latency: trigger M-cycle + one START M-cycle, then one OAM write per ce; only HRAM is CPU-reachable while copying.
module dmg_oam_dma (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_d_out,
  input  logic [7:0]  src_data,
  output logic [15:0] dma_src_addr,
  output logic        dma_active,
  output logic        cpu_grant,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_d_wr,
  output logic        oam_write,
  output logic [7:0]  reg_d_rd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'h9F;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] idx;
  logic [7:0] src_hi;
  logic [7:0] eff_hi;
  logic       trigger;

  // FF46 decode ignores cpu_grant so a running copy can always be restarted.
  assign trigger = ce && cpu_write && (cpu_addr == 16'hFF46);

  // Sources in E0-FF fold back onto the C0-DF work RAM through the echo mirror.
  assign eff_hi = (src_hi >= 8'hE0) ? (src_hi - 8'h20) : src_hi;

  always_comb begin
    state_nxt = state;
    if (trigger) begin
      state_nxt = START;
    end else if (ce) begin
      case (state)
        START:   state_nxt = XFER;
        XFER:    state_nxt = (idx == LAST_IDX) ? IDLE : XFER;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 8'h00;
      src_hi    <= 8'hFF;
      oam_addr  <= 8'h00;
      oam_d_wr  <= 8'h00;
      oam_write <= 1'b0;
    end else begin
      state     <= state_nxt;
      oam_write <= 1'b0;
      if (trigger) begin
        src_hi <= cpu_d_out;
        idx    <= 8'h00;
      end else if (ce && state == XFER) begin
        oam_d_wr  <= src_data;
        oam_addr  <= idx;
        oam_write <= 1'b1;
        idx       <= (idx == LAST_IDX) ? 8'h00 : idx + 8'h01;
      end
    end
  end

  assign dma_active   = (state == XFER);
  assign dma_src_addr = dma_active ? {eff_hi, idx} : 16'h0000;
  assign cpu_grant    = !dma_active || (cpu_addr[15:7] == 9'h1FF && cpu_addr != 16'hFFFF);
  assign reg_d_rd     = src_hi;

endmodule

// File: tb/tb_dmg_oam_dma.sv
// Directed bench for dmg_oam_dma: full copies, echo mirror, CPU bus gating, restart, freeze and reset abort.
module tb_dmg_oam_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic [15:0] cpu_addr = 16'h8000;
  logic        cpu_write = 1'b0;
  logic [7:0]  cpu_d_out = 8'h00;
  logic [7:0]  src_data;
  logic [15:0] dma_src_addr;
  logic        dma_active;
  logic        cpu_grant;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_d_wr;
  logic        oam_write;
  logic [7:0]  reg_d_rd;

  int checks = 0;
  int failures = 0;
  int mcount = 0;
  int stray = 0;

  always #5 clk = ~clk;

  // Deterministic bus memory: each address returns a byte derived from it.
  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign src_data = mem(dma_src_addr);

  dmg_oam_dma dut (
    .clk(clk), .rst(rst), .ce(ce), .cpu_addr(cpu_addr), .cpu_write(cpu_write),
    .cpu_d_out(cpu_d_out), .src_data(src_data), .dma_src_addr(dma_src_addr),
    .dma_active(dma_active), .cpu_grant(cpu_grant), .oam_addr(oam_addr),
    .oam_d_wr(oam_d_wr), .oam_write(oam_write), .reg_d_rd(reg_d_rd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One ce clock; returns #1 after the ce edge with ce low again.
  task automatic ce_cycle();
    ce = 1'b1;
    @(posedge clk);
    #1;
    ce = 1'b0;
    cpu_write = 1'b0;
    mcount++;
  endtask

  task automatic idle3();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic trigger(input logic [7:0] page);
    cpu_addr  = 16'hFF46;
    cpu_write = 1'b1;
    cpu_d_out = page;
    ce_cycle();
    cpu_addr  = 16'h8000;
  endtask

  task automatic xfer_bytes(input logic [15:0] base, input int first, input int last);
    logic [15:0] a;
    for (int i = first; i <= last; i++) begin
      a = base + 16'(i);
      chk("src_addr", 32'(dma_src_addr), 32'(a));
      ce_cycle();
      chk("oam_write_hi", 32'(oam_write), 32'd1);
      chk("oam_addr", 32'(oam_addr), 32'(i));
      chk("oam_d_wr", 32'(oam_d_wr), 32'(mem(a)));
      @(posedge clk);
      #1;
      chk("oam_write_1clk", 32'(oam_write), 32'd0);
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset, with ce held high to show reset wins regardless of ce.
    ce = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ce = 1'b0;
    rst = 1'b0;
    chk("rst_active", 32'(dma_active), 32'd0);
    chk("rst_grant", 32'(cpu_grant), 32'd1);
    chk("rst_reg", 32'(reg_d_rd), 32'hFF);
    chk("rst_oam_write", 32'(oam_write), 32'd0);
    chk("rst_oam_addr", 32'(oam_addr), 32'h00);
    chk("rst_oam_d_wr", 32'(oam_d_wr), 32'h00);
    chk("rst_src_addr", 32'(dma_src_addr), 32'h0000);
    idle3();

    // Page C1: full copy, length and bus gating.
    mcount = 0;
    trigger(8'hC1);
    chk("start_active", 32'(dma_active), 32'd0);
    chk("start_src_addr", 32'(dma_src_addr), 32'h0000);
    chk("start_reg", 32'(reg_d_rd), 32'hC1);
    idle3();
    ce_cycle();
    chk("xfer_active", 32'(dma_active), 32'd1);
    chk("start_no_write", 32'(oam_write), 32'd0);
    idle3();
    xfer_bytes(16'hC100, 0, 9);
    cpu_addr = 16'hFF90; #1; chk("grant_hram", 32'(cpu_grant), 32'd1);
    cpu_addr = 16'h8000; #1; chk("grant_vram", 32'(cpu_grant), 32'd0);
    cpu_addr = 16'hFFFF; #1; chk("grant_ie", 32'(cpu_grant), 32'd0);
    cpu_addr = 16'hFE00; #1; chk("grant_oam", 32'(cpu_grant), 32'd0);
    cpu_addr = 16'hFF80; #1; chk("grant_hram_lo", 32'(cpu_grant), 32'd1);
    cpu_addr = 16'h8000;
    xfer_bytes(16'hC100, 10, 159);
    chk("c1_idle", 32'(dma_active), 32'd0);
    chk("c1_length", 32'(mcount), 32'd162);
    chk("idle_grant", 32'(cpu_grant), 32'd1);
    chk("idle_src_addr", 32'(dma_src_addr), 32'h0000);
    idle3();
    ce_cycle();
    idle3();
    chk("idle_hold_addr", 32'(oam_addr), 32'h9F);
    chk("idle_no_write", 32'(oam_write), 32'd0);

    // Page E3 reads through the echo mirror at C3.
    trigger(8'hE3);
    idle3();
    ce_cycle();
    idle3();
    xfer_bytes(16'hC300, 0, 159);
    chk("e3_reg", 32'(reg_d_rd), 32'hE3);
    chk("e3_idle", 32'(dma_active), 32'd0);
    idle3();

    // Restart at idx 0x50 with page D0.
    trigger(8'h40);
    idle3();
    ce_cycle();
    idle3();
    xfer_bytes(16'h4000, 0, 'h4F);
    chk("pre_restart_src", 32'(dma_src_addr), 32'h4050);
    trigger(8'hD0);
    chk("restart_no_write", 32'(oam_write), 32'd0);
    chk("restart_addr_hold", 32'(oam_addr), 32'h4F);
    chk("restart_start", 32'(dma_active), 32'd0);
    chk("restart_reg", 32'(reg_d_rd), 32'hD0);
    idle3();
    ce_cycle();
    chk("restart_start_no_write", 32'(oam_write), 32'd0);
    chk("restart_xfer", 32'(dma_active), 32'd1);
    idle3();
    xfer_bytes(16'hD000, 0, 159);
    chk("restart_idle", 32'(dma_active), 32'd0);
    idle3();

    // Freeze with ce low for 100 clk mid-copy.
    trigger(8'h81);
    idle3();
    ce_cycle();
    idle3();
    xfer_bytes(16'h8100, 0, 'h0F);
    stray = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (oam_write !== 1'b0) stray++;
    end
    chk("freeze_no_write", 32'(stray), 32'd0);
    chk("freeze_src", 32'(dma_src_addr), 32'h8110);
    chk("freeze_oam_addr", 32'(oam_addr), 32'h0F);
    chk("freeze_oam_d_wr", 32'(oam_d_wr), 32'(mem(16'h810F)));
    chk("freeze_active", 32'(dma_active), 32'd1);
    xfer_bytes(16'h8100, 'h10, 'h1F);

    // Reset abort at idx 0x20, pulsed together with ce.
    chk("pre_rst_src", 32'(dma_src_addr), 32'h8120);
    rst = 1'b1;
    ce = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ce = 1'b0;
    chk("abort_oam_write", 32'(oam_write), 32'd0);
    chk("abort_active", 32'(dma_active), 32'd0);
    chk("abort_reg", 32'(reg_d_rd), 32'hFF);
    chk("abort_src_addr", 32'(dma_src_addr), 32'h0000);
    stray = 0;
    repeat (10) begin
      idle3();
      ce = 1'b1;
      @(posedge clk);
      #1;
      ce = 1'b0;
      if (oam_write !== 1'b0) stray++;
      if (dma_active !== 1'b0) stray++;
    end
    chk("abort_quiet", 32'(stray), 32'd0);
    chk("abort_grant", 32'(cpu_grant), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
